fetch_stage_ctrl: RTL and testbench
===================================

// Module: fetch_stage_ctrl
// PURPOSE
//  Consumer side of the hazard handshake: owns the PC register and IF/ID pipeline register.
//  Applies stall, pc_write, ifid_write and branch redirect, injects NOP bubbles on flush,
//  detects HLT at fetch and freezes the front end. Counts stall cycles for perf debug.
//  Sits between instruction memory (IF) and the decode stage.
// PARAMETERS
//  PC_W        16       PC / address width; PC advances by 2 (byte-addressed 16-bit instrs)
//  INSTR_W     16       instruction width
//  RESET_PC    16'h0000 PC value loaded on reset
//  NOP_INSTR   16'h0000 bubble pattern written into IF/ID on flush/halt drain
//  HALT_OPCODE 4'hF     opcode (instr[15:12]) of HLT
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous, active-low reset
//  stall         in   1        global stall from hazard detection unit
//  pc_write      in   1        PC write enable from hazard detection unit
//  ifid_write    in   1        IF/ID write enable from hazard detection unit
//  branch_taken  in   1        taken branch resolved in ID this cycle
//  branch_target in   PC_W     redirect address, valid with branch_taken
//  imem_instr    in   INSTR_W  instruction read combinationally at pc
//  pc            out  PC_W     current fetch address to imem
//  ifid_instr    out  INSTR_W  IF/ID instruction
//  ifid_pc_plus2 out  PC_W     IF/ID PC+2 of that instruction
//  ifid_valid    out  1        IF/ID holds a real instruction (0 = bubble)
//  halted        out  1        front end frozen after HLT
//  stall_count   out  16       saturating count of stalled cycles
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus2=0, ifid_valid=0,
//   halted=0, stall_count=0, state=RUN. Mid-operation reset overrides everything immediately.
//  pc_en = pc_write & ~stall; ifid_en = ifid_write & ~stall. stall=1 always holds PC and IF/ID.
//  FSM states RUN, HALT_WAIT, HALTED; halted = (state==HALTED).
//  RUN, priority high->low:
//   1. stall=1: hold all; branch_taken ignored (branch re-resolves after stall clears).
//   2. branch_taken: pc<=branch_target; IF/ID<=NOP_INSTR, ifid_valid<=0 (flush, 1 bubble);
//      branch wins over HLT decode in the same cycle (wrong-path HLT is discarded).
//   3. imem_instr[15:12]==HALT_OPCODE: if ifid_en, IF/ID<=HLT, pc+2, valid=1; pc held (not
//      incremented); state->HALT_WAIT only when ifid_en=1, else stay RUN and retry.
//   4. else: if pc_en pc<=pc+2 (wraps mod 2^PC_W, 16'hFFFE->16'h0000);
//      if ifid_en IF/ID<=imem_instr, pc+2, valid=1.
//   pc_en and ifid_en act independently (one may be 0 while the other is 1).
//  HALT_WAIT: pc held. When ~stall: IF/ID<=NOP_INSTR, valid<=0, state->HALTED.
//   branch_taken here cannot occur legally (ID holds HLT); ignored if asserted.
//  HALTED: pc and IF/ID frozen, all inputs ignored; exit only by reset.
//  stall_count: +1 each cycle stall=1 and state!=HALTED; saturates at 16'hFFFF.
//  Latency: imem_instr at pc in cycle N appears on ifid_instr after edge N+1 (1 cycle).
// TESTING
//  T1 reset: rst_n=0 mid-run with pc=16'h0010 -> pc=0, ifid_valid=0, stall_count=0 same cycle.
//  T2 stream: 4 non-HLT instrs, no stalls -> pc 0,2,4,6,8; ifid_pc_plus2 2,4,6,8; valid=1.
//  T3 stall: stall=1 for 3 cycles at pc=16'h0006 -> pc, IF/ID unchanged, stall_count +3;
//     branch_taken=1 during stall ignored.
//  T4 flush: branch_taken=1, target=16'h0040 at pc=16'h000A -> pc=16'h0040, ifid_instr=NOP,
//     valid=0 next cycle; HLT at imem same cycle not latched, state stays RUN.
//  T5 halt: HLT (16'hF000) at pc=16'h000C -> IF/ID=HLT, pc stays 16'h000C; next ~stall cycle
//     IF/ID=NOP, halted=1; later stall/branch have no effect.
//  T6 wrap+sat: pc=16'hFFFE -> 16'h0000; force 65536 stall cycles -> stall_count=16'hFFFF held.

Source files
------------

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: owns the PC and the IF/ID register. Applies the hazard
// unit's stall/write enables, flushes on a taken branch, freezes the front end
// once an HLT has been fetched, and keeps a saturating stall-cycle counter.
module fetch_stage_ctrl #(
  parameter int              PC_W        = 16,
  parameter int              INSTR_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               pc_write_i,
  input  logic               ifid_write_i,
  input  logic               branch_taken_i,
  input  logic [PC_W-1:0]    branch_target_i,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [PC_W-1:0]    ifid_pc_plus2_o,
  output logic               ifid_valid_o,
  output logic               halted_o,
  output logic [15:0]        stall_count_o
);

  typedef enum logic [1:0] {RUN, HALT_WAIT, HALTED} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc2_q, ifid_pc2_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;

  logic            pc_en, ifid_en, is_hlt;
  logic [PC_W-1:0] pc_plus2;

  assign pc_en    = pc_write_i & ~stall_i;
  assign ifid_en  = ifid_write_i & ~stall_i;
  assign is_hlt   = (imem_instr_i[INSTR_W-1 -: 4] == HALT_OPCODE);
  assign pc_plus2 = pc_q + PC_W'(2);  // wraps naturally at 2^PC_W

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next-state: HLT is only committed once it actually lands in IF/ID, and a
  // branch in the same cycle squashes it as wrong-path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (!stall_i && !branch_taken_i && is_hlt && ifid_en) state_d = HALT_WAIT;
      HALT_WAIT: if (!stall_i) state_d = HALTED;
      default:   state_d = HALTED;
    endcase
  end

  // Datapath next values per state; stall outranks everything, including branch.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc2_d   = ifid_pc2_q;
    ifid_valid_d = ifid_valid_q;
    stall_cnt_d  = stall_cnt_q;
    if (stall_i && state_q != HALTED && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    case (state_q)
      RUN: begin
        if (stall_i) begin
          // hold; the branch re-resolves once the stall drops
        end else if (branch_taken_i) begin
          pc_d         = branch_target_i;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (is_hlt) begin
          // PC parks on the HLT so nothing past it is ever fetched
          if (ifid_en) begin
            ifid_instr_d = imem_instr_i;
            ifid_pc2_d   = pc_plus2;
            ifid_valid_d = 1'b1;
          end
        end else begin
          if (pc_en) pc_d = pc_plus2;
          if (ifid_en) begin
            ifid_instr_d = imem_instr_i;
            ifid_pc2_d   = pc_plus2;
            ifid_valid_d = 1'b1;
          end
        end
      end
      HALT_WAIT: begin
        if (!stall_i) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc2_q   <= '0;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc2_q   <= ifid_pc2_d;
      ifid_valid_q <= ifid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign pc_o            = pc_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign ifid_pc_plus2_o = ifid_pc2_q;
  assign ifid_valid_o    = ifid_valid_q;
  assign halted_o        = (state_q == HALTED);
  assign stall_count_o   = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: stream, stall, flush, halt, async reset,
// PC wrap and stall counter saturation.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, pc_write, ifid_write, branch_taken;
  logic [15:0] branch_target, imem_instr;
  logic [15:0] pc, ifid_instr, ifid_pc_plus2, stall_count;
  logic        ifid_valid, halted;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_stage_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall),
    .pc_write_i      (pc_write),
    .ifid_write_i    (ifid_write),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .imem_instr_i    (imem_instr),
    .pc_o            (pc),
    .ifid_instr_o    (ifid_instr),
    .ifid_pc_plus2_o (ifid_pc_plus2),
    .ifid_valid_o    (ifid_valid),
    .halted_o        (halted),
    .stall_count_o   (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // advance one clock; sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] ins,
                          input logic [15:0] pc2, input logic v);
    chk({tag, ".instr"}, ifid_instr, ins);
    chk({tag, ".pc2"},   ifid_pc_plus2, pc2);
    chk({tag, ".valid"}, ifid_valid, v);
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; pc_write = 1; ifid_write = 1;
    branch_taken = 0; branch_target = '0; imem_instr = 16'h1000;
    tick(); tick();
    chk("rst.pc", pc, 16'h0000);
    chk_ifid("rst", 16'h0000, 16'h0000, 1'b0);
    chk("rst.halted", halted, 0);
    chk("rst.cnt", stall_count, 0);
    rst_n = 1'b1;

    // T2: stream of four non-HLT instructions
    for (int i = 0; i < 4; i++) begin
      imem_instr = 16'h1000 + 16'(i);
      tick();
      chk($sformatf("t2.pc%0d", i), pc, 16'(2 * (i + 1)));
      chk_ifid($sformatf("t2.%0d", i), 16'h1000 + 16'(i), 16'(2 * (i + 1)), 1'b1);
    end

    // T3: 3-cycle stall at pc 8 with a (ignored) branch request
    stall = 1; branch_taken = 1; branch_target = 16'h0040; imem_instr = 16'h2000;
    repeat (3) tick();
    chk("t3.pc", pc, 16'h0008);
    chk_ifid("t3", 16'h1003, 16'h0008, 1'b1);
    chk("t3.cnt", stall_count, 3);
    stall = 0; branch_taken = 0;
    tick();
    chk("t3.resume.pc", pc, 16'h000A);
    chk_ifid("t3.resume", 16'h2000, 16'h000A, 1'b1);

    // T4: branch at pc 0xA with HLT on imem -> flush, HLT discarded
    branch_taken = 1; branch_target = 16'h0040; imem_instr = 16'hF000;
    tick();
    chk("t4.pc", pc, 16'h0040);
    chk("t4.instr", ifid_instr, 16'h0000);
    chk("t4.valid", ifid_valid, 0);
    chk("t4.halted", halted, 0);
    branch_taken = 0; imem_instr = 16'h3000;
    tick();
    chk("t4.run.pc", pc, 16'h0042);
    chk_ifid("t4.run", 16'h3000, 16'h0042, 1'b1);

    // independent enables
    pc_write = 0; imem_instr = 16'h4000;
    tick();
    chk("en.pchold", pc, 16'h0042);
    chk_ifid("en.ifid", 16'h4000, 16'h0044, 1'b1);
    pc_write = 1; ifid_write = 0; imem_instr = 16'h5000;
    tick();
    chk("en.pcadv", pc, 16'h0044);
    chk_ifid("en.ifidhold", 16'h4000, 16'h0044, 1'b1);

    // T5: HLT with ifid_write=0 must retry, not halt
    imem_instr = 16'hF000;
    tick();
    chk("t5.retry.pc", pc, 16'h0044);
    chk("t5.retry.instr", ifid_instr, 16'h4000);
    ifid_write = 1;
    tick();
    chk("t5.pc", pc, 16'h0044);
    chk_ifid("t5.hlt", 16'hF000, 16'h0046, 1'b1);
    chk("t5.notyet", halted, 0);
    stall = 1;
    tick();
    chk("t5.waitstall.instr", ifid_instr, 16'hF000);
    chk("t5.waitstall.halted", halted, 0);
    chk("t5.cnt", stall_count, 4);
    stall = 0;
    tick();
    chk_ifid("t5.drain", 16'h0000, 16'h0046, 1'b0);
    chk("t5.halted", halted, 1);
    stall = 1; branch_taken = 1; branch_target = 16'h0080; imem_instr = 16'h1111;
    repeat (2) tick();
    chk("t5.frz.pc", pc, 16'h0044);
    chk("t5.frz.halted", halted, 1);
    chk("t5.frz.cnt", stall_count, 4);
    chk("t5.frz.valid", ifid_valid, 0);

    // reset exits HALTED
    rst_n = 0; stall = 0; branch_taken = 0;
    #1;
    chk("rst2.halted", halted, 0);
    tick();
    rst_n = 1;

    // T6a: wrap at 0xFFFE
    branch_taken = 1; branch_target = 16'hFFFE;
    tick();
    chk("t6.pcFFFE", pc, 16'hFFFE);
    branch_taken = 0; imem_instr = 16'h1234;
    tick();
    chk("t6.wrap.pc", pc, 16'h0000);
    chk_ifid("t6.wrap", 16'h1234, 16'h0000, 1'b1);

    // T1: async reset mid-run at pc 0x10 with a live counter
    branch_taken = 1; branch_target = 16'h000E;
    tick();
    branch_taken = 0; imem_instr = 16'h2222;
    tick();
    chk("t1.pre.pc", pc, 16'h0010);
    stall = 1;
    tick();
    chk("t1.pre.cnt", stall_count, 1);
    #2 rst_n = 0;
    #1;
    chk("t1.pc", pc, 16'h0000);
    chk("t1.valid", ifid_valid, 0);
    chk("t1.cnt", stall_count, 0);
    tick();
    rst_n = 1;

    // T6b: counter saturation (stall still high)
    repeat (65534) tick();
    chk("t6.cntFFFE", stall_count, 16'hFFFE);
    tick();
    chk("t6.cntFFFF", stall_count, 16'hFFFF);
    tick();
    chk("t6.sat", stall_count, 16'hFFFF);
    chk("t6.pc", pc, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
